// File: rtl/fifo_fill.sv
// fifo_fill: pattern source that pushes size*times words into a FIFO under
// ap_ctrl_hs-style handshaking. Words form a wrapping counter starting at
// seed and are grouped into `times` bursts of `size` words, with GAP idle
// cycles between bursts. Writing stalls while fifo_full is high.
//
// Optional feature macro: FIFO_FILL_CHECKSUM_EN adds the `checksum` output,
// the XOR of every word written in the current run.
//
// Ports:
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   size, times, seed  run parameters, latched when ap_start is accepted
//   fifo_wr_en         write strobe (combinational, gated by fifo_full)
//   fifo_wr_data       write data (registered)
//   fifo_full          FIFO full flag
//   ap_start           start request
//   ap_idle            high while in IDLE
//   ap_ready           one-cycle pulse when ap_start is accepted
//   ap_done            one-cycle pulse coincident with the last write
//   checksum           (FIFO_FILL_CHECKSUM_EN only) XOR of written words
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for ap_start; ap_idle high
// FILL  | writing words of the current burst
// GAP   | GAP idle cycles between bursts, no writes
module fifo_fill #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [31:0]      size,
    input  logic [31:0]      times,
    input  logic [WIDTH-1:0] seed,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_wr_data,
    input  logic             fifo_full,
    input  logic             ap_start,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             ap_done
`ifdef FIFO_FILL_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    // At least one bit wide so GAP=0 still elaborates cleanly.
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_GAP
    } state_t;

    state_t           state;
    logic [31:0]      size_r;
    logic [31:0]      times_r;
    logic [31:0]      size_cnt;
    logic [31:0]      times_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [WIDTH-1:0] data_r;

    logic start_acc;
    logic empty_run;
    logic wr;
    logic burst_end;
    logic last_word;

    always_comb begin
        start_acc = (state == S_IDLE) && ap_start;
        empty_run = (size == 32'd0) || (times == 32'd0);
        wr        = (state == S_FILL) && !fifo_full;
        burst_end = (size_cnt == size_r - 32'd1);
        last_word = burst_end && (times_cnt == times_r - 32'd1);
    end

    assign fifo_wr_en   = wr;
    assign fifo_wr_data = data_r;
    assign ap_idle      = (state == S_IDLE);
    assign ap_ready     = start_acc;
    // A zero-length run completes in the accept cycle itself.
    assign ap_done      = (start_acc && empty_run) || (wr && last_word);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            size_r    <= '0;
            times_r   <= '0;
            size_cnt  <= '0;
            times_cnt <= '0;
            gap_cnt   <= '0;
            data_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        size_r    <= size;
                        times_r   <= times;
                        data_r    <= seed;
                        size_cnt  <= '0;
                        times_cnt <= '0;
                        gap_cnt   <= '0;
                        if (!empty_run)
                            state <= S_FILL;
                    end
                end
                S_FILL: begin
                    // fifo_full holds every register in place.
                    if (wr) begin
                        data_r <= data_r + WIDTH'(1);
                        if (last_word) begin
                            state <= S_IDLE;
                        end else if (burst_end) begin
                            size_cnt  <= '0;
                            times_cnt <= times_cnt + 32'd1;
                            if (GAP > 0) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= S_GAP;
                            end
                        end else begin
                            size_cnt <= size_cnt + 32'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0)
                        state <= S_FILL;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FIFO_FILL_CHECKSUM_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            checksum <= '0;
        else if (start_acc)
            checksum <= '0;
        else if (wr)
            checksum <= checksum ^ data_r;
    end
`endif

endmodule

// File: tb/tb_fifo_fill.sv
module tb_fifo_fill;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] size = '0;
    logic [31:0] times = '0;
    logic [7:0]  seed = '0;
    logic        fifo_full = 1'b0;
    logic        ap_start = 1'b0;

    logic       wr_en [2];
    logic [7:0] wr_data [2];
    logic       idle [2];
    logic       ready [2];
    logic       done [2];
`ifdef FIFO_FILL_CHECKSUM_EN
    logic [7:0] csum [2];
`endif

    always #5 ap_clk = ~ap_clk;

    fifo_fill #(.WIDTH(8), .GAP(0)) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .size(size), .times(times), .seed(seed),
        .fifo_wr_en(wr_en[0]), .fifo_wr_data(wr_data[0]), .fifo_full(fifo_full),
        .ap_start(ap_start), .ap_idle(idle[0]), .ap_ready(ready[0]), .ap_done(done[0])
`ifdef FIFO_FILL_CHECKSUM_EN
        , .checksum(csum[0])
`endif
    );

    fifo_fill #(.WIDTH(8), .GAP(3)) dut3 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .size(size), .times(times), .seed(seed),
        .fifo_wr_en(wr_en[1]), .fifo_wr_data(wr_data[1]), .fifo_full(fifo_full),
        .ap_start(ap_start), .ap_idle(idle[1]), .ap_ready(ready[1]), .ap_done(done[1])
`ifdef FIFO_FILL_CHECKSUM_EN
        , .checksum(csum[1])
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run progress counted in words; a burst boundary is
    // any word count that is a multiple of size, followed by G silent cycles.
    int       G [2] = '{0, 3};
    bit       m_busy [2];
    int       m_n [2];
    int       m_total [2];
    int       m_sz [2];
    int       m_gap [2];
    logic [7:0] m_seed [2];
    logic [7:0] m_chk [2];

    bit         e_gap, e_wr, e_idle, e_ready, e_done;
    logic [7:0] e_data;

    int cyc = 0;
    logic [7:0] q0 [$];
    int w0 [$];
    int w3 [$];
    int r0cyc = 0;
    int r3cyc = 0;
    int done_cnt [2] = '{0, 0};
    int ready_cnt [2] = '{0, 0};

    always @(negedge ap_clk) begin
        cyc++;
        if (!ap_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_n[i] = 0; m_total[i] = 0; m_sz[i] = 1;
                m_gap[i] = 0; m_seed[i] = 8'h00; m_chk[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_gap   = m_busy[i] && (m_gap[i] > 0);
                e_wr    = m_busy[i] && !e_gap && !fifo_full;
                e_idle  = !m_busy[i];
                e_ready = !m_busy[i] && ap_start;
                e_done  = (e_ready && (size == 0 || times == 0)) ||
                          (e_wr && (m_n[i] == m_total[i] - 1));
                e_data  = 8'(m_seed[i] + 8'(m_n[i]));

                check($sformatf("wr_en[%0d]", i), 64'(wr_en[i]), 64'(e_wr));
                check($sformatf("idle[%0d]", i), 64'(idle[i]), 64'(e_idle));
                check($sformatf("ready[%0d]", i), 64'(ready[i]), 64'(e_ready));
                check($sformatf("done[%0d]", i), 64'(done[i]), 64'(e_done));
                if (e_wr)
                    check($sformatf("wr_data[%0d]", i), 64'(wr_data[i]), 64'(e_data));
`ifdef FIFO_FILL_CHECKSUM_EN
                check($sformatf("checksum[%0d]", i), 64'(csum[i]), 64'(m_chk[i]));
`endif

                if (e_ready) begin
                    m_seed[i] = seed; m_n[i] = 0; m_chk[i] = 8'h00; m_gap[i] = 0;
                    if (size != 0 && times != 0) begin
                        m_busy[i]  = 1;
                        m_total[i] = int'(size * times);
                        m_sz[i]    = int'(size);
                    end
                end else if (e_wr) begin
                    m_chk[i] = m_chk[i] ^ e_data;
                    m_n[i]++;
                    if (m_n[i] == m_total[i])
                        m_busy[i] = 0;
                    else if (m_n[i] % m_sz[i] == 0)
                        m_gap[i] = G[i];
                end else if (e_gap) begin
                    m_gap[i]--;
                end
            end

            if (wr_en[0]) begin q0.push_back(wr_data[0]); w0.push_back(cyc); end
            if (wr_en[1]) w3.push_back(cyc);
            if (ready[0]) r0cyc = cyc;
            if (ready[1]) r3cyc = cyc;
            for (int i = 0; i < 2; i++) begin
                if (done[i]) done_cnt[i]++;
                if (ready[i]) ready_cnt[i]++;
            end
        end
    end

    task automatic clear_logs();
        q0.delete(); w0.delete(); w3.delete();
    endtask

    task automatic start_run(input logic [31:0] s, input logic [31:0] t, input logic [7:0] sd);
        @(posedge ap_clk); #1;
        clear_logs();
        size = s; times = t; seed = sd; fifo_full = 1'b0; ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rand_full);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge ap_clk); #1;
            if (rand_full) fifo_full = 1'($urandom_range(0, 1));
            @(negedge ap_clk);
            if (idle[0] && idle[1]) begin ok = 1; break; end
        end
        @(posedge ap_clk); #1;
        fifo_full = 1'b0;
        check("wait_idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_wr_en[%0d]", tag, i), 64'(wr_en[i]), 64'd0);
            check($sformatf("%s_wr_data[%0d]", tag, i), 64'(wr_data[i]), 64'd0);
            check($sformatf("%s_idle[%0d]", tag, i), 64'(idle[i]), 64'd1);
            check($sformatf("%s_ready[%0d]", tag, i), 64'(ready[i]), 64'd0);
            check($sformatf("%s_done[%0d]", tag, i), 64'(done[i]), 64'd0);
`ifdef FIFO_FILL_CHECKSUM_EN
            check($sformatf("%s_checksum[%0d]", tag, i), 64'(csum[i]), 64'd0);
`endif
        end
    endtask

    int exp_gap3 [6] = '{1, 2, 6, 7, 11, 12};
    logic [7:0] exp_wrap [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    initial begin
        int errs;
        int d0, d3, r0;
        bit ok;

        #2;
        check_reset_outputs("por");
        repeat (3) @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;

        // Back-to-back bursts, seed 0x10.
        start_run(32'd4, 32'd2, 8'h10);
        wait_idle(60, 0);
        check("t1_count", 64'(q0.size()), 64'd8);
        errs = 0;
        for (int k = 0; k < q0.size() && k < 8; k++)
            if (q0[k] !== 8'(8'h10 + k)) errs++;
        check("t1_data", 64'(errs), 64'd0);
        errs = 0;
        for (int k = 0; k < w0.size(); k++)
            if (w0[k] - r0cyc != k + 1) errs++;
        check("t1_back_to_back", 64'(errs), 64'd0);

        // Data wrap.
        start_run(32'd4, 32'd1, 8'hFE);
        wait_idle(60, 0);
        check("t2_count", 64'(q0.size()), 64'd4);
        errs = 0;
        for (int k = 0; k < q0.size() && k < 4; k++)
            if (q0[k] !== exp_wrap[k]) errs++;
        check("t2_wrap_data", 64'(errs), 64'd0);
`ifdef FIFO_FILL_CHECKSUM_EN
        check("t2_checksum", 64'(csum[0]), 64'h00);
`endif

        // GAP=3 instance: pairs separated by 3 silent cycles.
        start_run(32'd2, 32'd3, 8'h00);
        wait_idle(60, 0);
        check("t3_count", 64'(w3.size()), 64'd6);
        errs = 0;
        for (int k = 0; k < w3.size() && k < 6; k++)
            if (w3[k] - r3cyc != exp_gap3[k]) errs++;
        check("t3_gap_pattern", 64'(errs), 64'd0);

        // Random backpressure.
        d0 = done_cnt[0]; d3 = done_cnt[1];
        start_run(32'd16, 32'd4, 8'h80);
        wait_idle(600, 1);
        check("t4_count", 64'(q0.size()), 64'd64);
        errs = 0;
        for (int k = 0; k < q0.size(); k++)
            if (q0[k] !== 8'(8'h80 + k)) errs++;
        check("t4_sequence", 64'(errs), 64'd0);
        check("t4_done0", 64'(done_cnt[0] - d0), 64'd1);
        check("t4_done3", 64'(done_cnt[1] - d3), 64'd1);

        // Zero-size run.
        d0 = done_cnt[0]; r0 = ready_cnt[0];
        start_run(32'd0, 32'd5, 8'h33);
        wait_idle(10, 0);
        check("t5_writes", 64'(q0.size()), 64'd0);
        check("t5_ready", 64'(ready_cnt[0] - r0), 64'd1);
        check("t5_done", 64'(done_cnt[0] - d0), 64'd1);

        // ap_start and input changes while busy are ignored.
        d0 = done_cnt[0]; r0 = ready_cnt[0];
        start_run(32'd8, 32'd2, 8'h00);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_start = 1'b1; size = 32'd99; times = 32'd7; seed = 8'hAA;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        wait_idle(100, 0);
        check("t6_ready", 64'(ready_cnt[0] - r0), 64'd1);
        check("t6_done", 64'(done_cnt[0] - d0), 64'd1);
        check("t6_count", 64'(q0.size()), 64'd16);

        // Reset mid-run after 3 of 8 words.
        start_run(32'd8, 32'd1, 8'h20);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ap_clk);
            if (q0.size() == 3) begin ok = 1; break; end
        end
        check("t7_reach3", 64'(ok), 64'd1);
        d0 = done_cnt[0];
        @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;
        check("t7_no_done", 64'(done_cnt[0] - d0), 64'd0);
        start_run(32'd4, 32'd1, 8'h40);
        wait_idle(60, 0);
        check("t7_count", 64'(q0.size()), 64'd4);
        if (q0.size() > 0)
            check("t7_first", 64'(q0[0]), 64'h40);
        else
            check("t7_first_missing", 64'd0, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
